palindrome_serializer: RTL
==========================

Name: palindrome_serializer

Overview:
- Generates palindromic words for the 3-bit/N-bit palindrome checkers and streams them out bit-serially.
- Accepts a half-word plus an odd/even flag on a valid/ready input handshake.
- Emits the mirrored full word MSB-first, one bit per accepted output beat, with last-bit marking.
- Serves as the stimulus/transmit end feeding palindrome checkers in system-level benches and datapaths.

Parameters:
HALF_W, 4, width of the half-word seed; legal range 1..16; full word length is 2*HALF_W (even) or 2*HALF_W-1 (odd).

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  seed present
in_ready  output  1  block can accept a seed (high only in IDLE)
in_half  input  HALF_W  seed bits h[HALF_W-1:0]
in_odd  input  1  1 = odd-length word, center bit h[0] not repeated
out_valid  output  1  out_bit valid
out_ready  input  1  sink accepts out_bit this cycle
out_bit  output  1  current serial bit
out_last  output  1  high with the final bit of the word

Behaviour:
- Reset (asynchronous assert, synchronous deassert to clk):
  - state=IDLE; out_valid=0, out_bit=0, out_last=0, in_ready=1.
  - Internal seed, odd flag and index are cleared.
- States: IDLE, FWD, REV. in_ready = (state==IDLE); no registered delay.
- IDLE:
  - On in_valid&&in_ready, register in_half and in_odd, set idx=HALF_W-1, go to FWD.
  - out_valid rises the next cycle, so the first bit appears 1 cycle after acceptance.
- FWD:
  - out_bit=h[idx], out_valid=1.
  - On a beat (out_valid&&out_ready) with idx>0: idx decrements.
  - On a beat with idx==0:
    - if odd && HALF_W==1: word done, go to IDLE;
    - else if odd: idx=1, go to REV;
    - else: idx=0, go to REV.
- REV:
  - out_bit=h[idx], out_valid=1.
  - On a beat with idx<HALF_W-1: idx increments.
  - On a beat with idx==HALF_W-1: word done, go to IDLE.
- out_last is high on exactly one bit per word:
  - in REV when idx==HALF_W-1;
  - in FWD when idx==0, odd=1 and HALF_W==1.
- Emitted sequence:
  - even: h[N-1..0] followed by h[0..N-1];
  - odd: h[N-1..0] followed by h[1..N-1].
- Stall: while out_valid && !out_ready, out_bit, out_last, idx and state are held stable. out_valid never drops without a beat.
- Input changes: in_half and in_odd are sampled only at acceptance. Changes after acceptance do not affect the word in flight.
- Throughput:
  - No new seed is accepted until the last beat completes. in_ready returns high the cycle after the last beat.
  - Minimum gap between words is 1 idle cycle. Max rate is L bits per L+1 cycles.
- Reset mid-word: the word is abandoned immediately, outputs return to reset values, and there is no partial resume.

Optional Feature:
- Macro PALINDROME_SERIALIZER_WORD_CNT_EN.
- When defined:
  - Extra output word_cnt [15:0] counts completed words.
  - It increments on each beat where out_last=1 and wraps from 16'hFFFF to 16'h0000.
  - Reset value is 0.
- When not defined, the port and counter do not exist and behaviour is otherwise identical.

Test Plan:
- HALF_W=4, in_half=4'b1101, in_odd=0, out_ready=1 -> bits 1,1,0,1,1,0,1,1; out_last only on 8th bit; in_ready high again the cycle after.
- HALF_W=4, in_half=4'b1101, in_odd=1 -> bits 1,1,0,1,0,1,1 (7 bits); out_last on 7th; each word fed to a checker reports palindrome=1.
- Stall: same even word, out_ready low 3 cycles during bit 3 -> out_bit holds 0 and out_valid holds 1; sequence is unchanged afterwards; in_half changed mid-word has no effect.
- Reset: rst_n pulsed low at bit 5 -> out_valid=0 and in_ready=1 immediately (asynchronous); the next seed 4'b0001 even -> 0,0,0,1,1,0,0,0.
- HALF_W=1: seed 1, odd=1 -> single bit 1 with out_last=1; seed 1, odd=0 -> 1,1 with out_last on 2nd bit.
- With PALINDROME_SERIALIZER_WORD_CNT_EN: send 3 back-to-back words -> word_cnt=3; a forced count of 16'hFFFF plus one word -> 0.

Source files
------------

// File: rtl/palindrome_serializer.sv
// Bit-serial palindrome generator: takes a half-word seed and streams the mirrored word MSB-first.
// Optional completed-word counter output enabled by PALINDROME_SERIALIZER_WORD_CNT_EN.
module palindrome_serializer #(
  parameter int HALF_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HALF_W-1:0] in_half,
  input  logic              in_odd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic              out_last
`ifdef PALINDROME_SERIALIZER_WORD_CNT_EN
  ,
  output logic [15:0]       word_cnt
`endif
);

  localparam int                IDX_W      = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam int                HALF_EXT_W = 1 << IDX_W;
  localparam logic [IDX_W-1:0]  IDX_MAX    = IDX_W'(HALF_W - 1);
  localparam bit                SINGLE     = (HALF_W == 1);

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    REV
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic [HALF_W-1:0]     r_half;
  logic                  r_odd;
  logic [HALF_EXT_W-1:0] w_half_ext;
  logic                  w_accept;
  logic                  w_beat;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state != IDLE);
  assign w_accept  = in_valid && in_ready;
  assign w_beat    = out_valid && out_ready;

  // Zero-extend the seed so the index can address every value it can hold.
  assign w_half_ext = HALF_EXT_W'(r_half);
  assign out_bit    = out_valid ? w_half_ext[r_idx] : 1'b0;
  assign out_last   = ((r_state == REV) && (r_idx == IDX_MAX)) ||
                      ((r_state == FWD) && (r_idx == '0) && r_odd && SINGLE);

  always_comb begin
    // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_idx_nxt   = IDX_MAX;
          w_state_nxt = FWD;
        end
      end
      FWD: begin
        if (w_beat) begin
          if (r_idx != '0) begin
            w_idx_nxt = r_idx - 1'b1;
          end else if (r_odd && SINGLE) begin
            w_state_nxt = IDLE;
          end else if (r_odd) begin
            // Odd words skip the centre bit on the way back.
            w_idx_nxt   = IDX_W'(1);
            w_state_nxt = REV;
          end else begin
            w_idx_nxt   = '0;
            w_state_nxt = REV;
          end
        end
      end
      REV: begin
        if (w_beat) begin
          if (r_idx == IDX_MAX) begin
            w_state_nxt = IDLE;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // NOTE: the seed is data, but it is cleared on reset so out_bit is defined from the first cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_half <= '0;
      r_odd  <= 1'b0;
    end else if (w_accept) begin
      r_half <= in_half;
      r_odd  <= in_odd;
    end
  end

`ifdef PALINDROME_SERIALIZER_WORD_CNT_EN
  logic [15:0] r_word_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_cnt <= '0;
    end else if (w_beat && out_last) begin
      r_word_cnt <= r_word_cnt + 16'd1;
    end
  end

  assign word_cnt = r_word_cnt;
`endif

endmodule
